ram_arbiter: RTL

Single-port RAM arbiter between the CPU bus and the video fetch unit, sitting directly upstream of the synchronous 8-bit RAM blocks (one-cycle registered read, write-through output). Each cycle the block grants at most one requester, drives the RAM address, data and write strobe, and returns read data to the winner with a fixed two-cycle latency. Video has priority. A wait counter guarantees the CPU a slot within MAXWAIT cycles.

---
 rtl/ram_arbiter_if.sv | 33 +++
 rtl/ram_arbiter.sv | 82 ++++++++
 2 files changed

// File: rtl/ram_arbiter_if.sv
// Bus bundle joining the CPU port, the video fetch port and the RAM block to the arbiter.
// slave: the arbiter's view of the bundle. master: the requesters and RAM side.
interface ram_arbiter_if #(
   parameter int AW = 14
);
   logic          cpu_req;
   logic          cpu_we;
   logic [AW-1:0] cpu_a;
   logic [7:0]    cpu_d;
   logic [7:0]    cpu_q;
   logic          cpu_ack;

   logic          vid_req;
   logic [AW-1:0] vid_a;
   logic          vid_gnt;
   logic [7:0]    vid_q;
   logic          vid_valid;

   logic [AW-1:0] ram_a;
   logic [7:0]    ram_d;
   logic          ram_w;
   logic [7:0]    ram_q;

   modport slave (
      input  cpu_req, cpu_we, cpu_a, cpu_d, vid_req, vid_a, ram_q,
      output cpu_q, cpu_ack, vid_gnt, vid_q, vid_valid, ram_a, ram_d, ram_w
   );

   modport master (
      output cpu_req, cpu_we, cpu_a, cpu_d, vid_req, vid_a, ram_q,
      input  cpu_q, cpu_ack, vid_gnt, vid_q, vid_valid, ram_a, ram_d, ram_w
   );
endinterface

// File: rtl/ram_arbiter.sv
// Single-port RAM arbiter: video has priority, a wait counter forces a CPU slot after MAXWAIT losses.
// Read data returns exactly 2 cycles after grant; requesters hold req until granted, results are never stalled.
module ram_arbiter #(
   parameter int AW      = 14,
   parameter int MAXWAIT = 4
) (
   input  logic          clock,
   input  logic          reset,
   ram_arbiter_if.slave  bus
);
   localparam logic [3:0] WAIT_MAX = 4'(MAXWAIT);

   logic       cpu_busy;
   logic [3:0] wait_cnt;
   logic       s1_vld;
   logic       s1_cpu;
   logic       cpu_ack_r;
   logic       vid_valid_r;
   logic [7:0] cpu_q_r;
   logic [7:0] vid_q_r;

   logic cpu_elig;
   logic force_cpu;
   logic cpu_win;
   logic vid_win;

   always_comb begin
      cpu_elig  = bus.cpu_req & ~cpu_busy;
      force_cpu = cpu_elig & (wait_cnt == WAIT_MAX);
      vid_win   = bus.vid_req & ~force_cpu;
      cpu_win   = cpu_elig & ~vid_win;
   end

   // RAM write strobe is gated by reset so a held CPU write cannot corrupt memory during reset.
   assign bus.ram_a   = cpu_win ? bus.cpu_a : bus.vid_a;
   assign bus.ram_d   = bus.cpu_d;
   assign bus.ram_w   = cpu_win & bus.cpu_we & reset;
   assign bus.vid_gnt = vid_win;

   assign bus.cpu_ack   = cpu_ack_r;
   assign bus.vid_valid = vid_valid_r;
   assign bus.cpu_q     = cpu_q_r;
   assign bus.vid_q     = vid_q_r;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cpu_busy <= 1'b0;
         wait_cnt <= 4'd0;
      end else begin
         if (cpu_win)
            cpu_busy <= 1'b1;
         else if (cpu_ack_r)
            cpu_busy <= 1'b0;

         if (cpu_win || !cpu_elig)
            wait_cnt <= 4'd0;
         else if (vid_win && wait_cnt != WAIT_MAX)
            wait_cnt <= wait_cnt + 4'd1;
      end
   end

   // Tag stage 1 follows the grant; stage 2 is the registered result and its pulse.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         s1_vld      <= 1'b0;
         s1_cpu      <= 1'b0;
         cpu_ack_r   <= 1'b0;
         vid_valid_r <= 1'b0;
         cpu_q_r     <= 8'h00;
         vid_q_r     <= 8'h00;
      end else begin
         s1_vld      <= cpu_win | vid_win;
         s1_cpu      <= cpu_win;
         cpu_ack_r   <= s1_vld & s1_cpu;
         vid_valid_r <= s1_vld & ~s1_cpu;
         if (s1_vld && s1_cpu)
            cpu_q_r <= bus.ram_q;
         if (s1_vld && !s1_cpu)
            vid_q_r <= bus.ram_q;
      end
   end
endmodule
